// File: rtl/spi_master_mc_if.sv
// rtl/spi_master_mc_if.sv - SPI master front-end/pin bundle; lsb_first exists only with SPI_LSB_FIRST_EN
interface spi_master_mc_if #(
    parameter int D_PACK = 8,
    parameter int N_SS   = 4,
    parameter int DIV_W  = 8
);
    localparam int SEL_W = $clog2(N_SS);

    logic              start;
    logic [SEL_W-1:0]  ss_sel;
    logic              c_pol;
    logic              c_ph;
    logic [DIV_W-1:0]  clk_div;
    logic [D_PACK-1:0] tx_data;
    logic              miso;
    logic              sck;
    logic              mosi;
    logic [N_SS-1:0]   ss_n;
    logic              busy;
    logic [D_PACK-1:0] rx_data;
    logic              rx_valid;

`ifdef SPI_LSB_FIRST_EN
    logic              lsb_first;

    modport master (
        input  start, ss_sel, c_pol, c_ph, clk_div, tx_data, miso, lsb_first,
        output sck, mosi, ss_n, busy, rx_data, rx_valid
    );
    modport slave (
        output start, ss_sel, c_pol, c_ph, clk_div, tx_data, miso, lsb_first,
        input  sck, mosi, ss_n, busy, rx_data, rx_valid
    );
`else
    modport master (
        input  start, ss_sel, c_pol, c_ph, clk_div, tx_data, miso,
        output sck, mosi, ss_n, busy, rx_data, rx_valid
    );
    modport slave (
        output start, ss_sel, c_pol, c_ph, clk_div, tx_data, miso,
        input  sck, mosi, ss_n, busy, rx_data, rx_valid
    );
`endif
endinterface

// File: rtl/spi_master_mc.sv
// rtl/spi_master_mc.sv - multi-slave SPI master, runtime CPOL/CPHA/divider; SPI_LSB_FIRST_EN adds LSB-first frames
module spi_master_mc #(
    parameter int D_PACK = 8,
    parameter int N_SS   = 4,
    parameter int DIV_W  = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    spi_master_mc_if.master bus
);
    localparam int EDGES = 2 * D_PACK;
    localparam int EW    = $clog2(EDGES + 1);
    localparam int SEL_W = $clog2(N_SS);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]     edge_q, edge_d;
    logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic              sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d;
    logic              rx_valid_q, rx_valid_d;
    logic [N_SS-1:0]   ss_n_q, ss_n_d;
    logic [D_PACK-1:0] tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic              period_end, leading, sel_ok, lsb_in;

`ifdef SPI_LSB_FIRST_EN
    assign lsb_in = bus.lsb_first;
`else
    assign lsb_in = 1'b0;
`endif

    // A power-of-two slave count makes every select index legal.
    if ((1 << SEL_W) == N_SS) begin : g_sel_full
        assign sel_ok = 1'b1;
    end else begin : g_sel_range
        assign sel_ok = (bus.ss_sel < SEL_W'(N_SS));
    end

    function automatic logic first_bit(input logic [D_PACK-1:0] v, input logic lsb);
        return lsb ? v[0] : v[D_PACK-1];
    endfunction

    function automatic logic [D_PACK-1:0] shift_tx(input logic [D_PACK-1:0] v, input logic lsb);
        return lsb ? (v >> 1) : (v << 1);
    endfunction

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ss_n_q     <= '1;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            rx_valid_q <= rx_valid_d;
            ss_n_q     <= ss_n_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        busy_d     = busy_q;
        rx_valid_d = 1'b0;
        ss_n_d     = ss_n_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        period_end = (cnt_q == div_q);
        // edge_q counts edges already made, so the coming edge is odd (leading) when edge_q is even
        leading    = ~edge_q[0];

        case (state_q)
            IDLE: begin
                if (bus.start && sel_ok) begin
                    state_d = LEAD;
                    cnt_d   = '0;
                    edge_d  = '0;
                    div_d   = bus.clk_div;
                    cpol_d  = bus.c_pol;
                    cpha_d  = bus.c_ph;
                    lsb_d   = lsb_in;
                    busy_d  = 1'b1;
                    ss_n_d  = ~(N_SS'(1) << bus.ss_sel);
                    sck_d   = bus.c_pol;
                    tx_d    = bus.tx_data;
                    if (!bus.c_ph) begin
                        mosi_d = first_bit(bus.tx_data, lsb_in);
                        tx_d   = shift_tx(bus.tx_data, lsb_in);
                    end
                end
            end
            LEAD, XFER: begin
                cnt_d = period_end ? '0 : cnt_q + 1'b1;
                if (period_end) begin
                    if (edge_q == EW'(EDGES)) begin
                        state_d = TRAIL;
                    end else begin
                        state_d = XFER;
                        edge_d  = edge_q + 1'b1;
                        sck_d   = ~sck_q;
                        if (leading ^ cpha_q) begin
                            rx_sh_d = lsb_q ? {bus.miso, rx_sh_q[D_PACK-1:1]}
                                            : {rx_sh_q[D_PACK-2:0], bus.miso};
                        end else if (edge_q != EW'(EDGES - 1)) begin
                            mosi_d = first_bit(tx_q, lsb_q);
                            tx_d   = shift_tx(tx_q, lsb_q);
                        end
                    end
                end
            end
            TRAIL: begin
                cnt_d = period_end ? '0 : cnt_q + 1'b1;
                sck_d = cpol_q;
                if (period_end) begin
                    state_d    = IDLE;
                    busy_d     = 1'b0;
                    ss_n_d     = '1;
                    rx_data_d  = rx_sh_q;
                    rx_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.sck      = sck_q;
    assign bus.mosi     = mosi_q;
    assign bus.ss_n     = ss_n_q;
    assign bus.busy     = busy_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
endmodule

// File: tb/tb_spi_master_mc.sv
// tb/tb_spi_master_mc.sv - randomized self-checking bench for spi_master_mc with a behavioural SPI slave
module tb_spi_master_mc;
    localparam int D  = 8;
    localparam int NS = 4;
    localparam int DW = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    spi_master_mc_if #(.D_PACK(D), .N_SS(NS), .DIV_W(DW)) bus ();
    spi_master_mc_if #(.D_PACK(D), .N_SS(3), .DIV_W(DW)) bus3 ();

    spi_master_mc #(.D_PACK(D), .N_SS(NS), .DIV_W(DW)) dut  (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));
    spi_master_mc #(.D_PACK(D), .N_SS(3), .DIV_W(DW))  dut3 (.clk_i(clk), .rst_n_i(rst_n), .bus(bus3));

    always #5 clk = ~clk;

    logic loop_en  = 1'b1;
    logic slv_miso = 1'b0;
    assign bus.miso  = loop_en ? bus.mosi : slv_miso;
    assign bus3.miso = bus3.mosi;

    // Observers and a mode-aware SPI slave, all sampled on the falling clock edge.
    int            busy_tot = 0, edge_tot = 0, rxv_tot = 0, ss_bad_tot = 0, busy3_tot = 0, rxv3_tot = 0;
    logic [NS-1:0] exp_ss   = '1;
    logic          cfg_cpol = 1'b0, cfg_cpha = 1'b0;
    logic          sck_prev = 1'b0, busy_prev = 1'b0;
    logic [NS-1:0] ss_prev  = '1;
    logic [D-1:0]  slv_word = '0, slv_sh = '0, slv_rx = '0;
    int            slv_nbits = 0;
    logic          slv_first = 1'b0;
    logic [D-1:0]  rx_q[$];

    always @(negedge clk) begin
        if (bus.busy) busy_tot <= busy_tot + 1;
        if (bus.busy && busy_prev && bus.sck !== sck_prev) edge_tot <= edge_tot + 1;
        if (bus.busy && bus.ss_n !== exp_ss) ss_bad_tot <= ss_bad_tot + 1;
        if (bus.rx_valid) begin
            rxv_tot <= rxv_tot + 1;
            rx_q.push_back(bus.rx_data);
        end
        if (bus3.busy) busy3_tot <= busy3_tot + 1;
        if (bus3.rx_valid) rxv3_tot <= rxv3_tot + 1;
        if (&ss_prev && !(&bus.ss_n)) begin
            slv_rx    <= '0;
            slv_nbits <= 0;
            if (!cfg_cpha) begin
                slv_miso <= slv_word[D-1];
                slv_sh   <= slv_word << 1;
            end else begin
                slv_sh   <= slv_word;
            end
        end else if (!(&bus.ss_n) && bus.sck !== sck_prev) begin
            if ((bus.sck !== cfg_cpol) != cfg_cpha) begin
                slv_rx <= {slv_rx[D-2:0], bus.mosi};
                if (slv_nbits == 0) slv_first <= bus.mosi;
                slv_nbits <= slv_nbits + 1;
            end else begin
                slv_miso <= slv_sh[D-1];
                slv_sh   <= slv_sh << 1;
            end
        end
        sck_prev  <= bus.sck;
        busy_prev <= bus.busy;
        ss_prev   <= bus.ss_n;
    end

    task automatic start_frame(input logic [D-1:0] tx, input logic [1:0] sel, input logic cpol,
                               input logic cpha, input logic [DW-1:0] div);
        bus.tx_data = tx;
        bus.ss_sel  = sel;
        bus.c_pol   = cpol;
        bus.c_ph    = cpha;
        bus.clk_div = div;
        cfg_cpol    = cpol;
        cfg_cpha    = cpha;
        exp_ss      = ~(NS'(1) << sel);
        bus.start   = 1'b1;
        @(negedge clk); #1;
        bus.start   = 1'b0;
    endtask

    task automatic wait_rx(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus.rx_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic wait_edges(input int e0, input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (edge_tot - e0 >= n) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    // One frame with full checking against the expected slave/loopback result and frame timing.
    task automatic check_frame(input string name, input logic [D-1:0] tx, input logic [1:0] sel,
                               input logic cpol, input logic cpha, input logic [DW-1:0] div,
                               input logic loop, input logic [D-1:0] word);
        int b0, e0, s0, h;
        bit ok;
        logic [D-1:0] exp_rx;
        h        = int'(div) + 1;
        loop_en  = loop;
        slv_word = word;
        exp_rx   = loop ? tx : word;
        b0 = busy_tot; e0 = edge_tot; s0 = ss_bad_tot;
        start_frame(tx, sel, cpol, cpha, div);
        wait_rx((2 * D + 2) * h + 10, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL %s rx_valid timeout: got none want pulse", name); end
        n_cmp++;
        if (bus.rx_data !== exp_rx) begin n_bad++; $display("FAIL %s rx_data: got %h want %h", name, bus.rx_data, exp_rx); end
        n_cmp++;
        if (busy_tot - b0 != (2 * D + 2) * h) begin n_bad++; $display("FAIL %s busy cycles: got %0d want %0d", name, busy_tot - b0, (2 * D + 2) * h); end
        n_cmp++;
        if (edge_tot - e0 != 2 * D) begin n_bad++; $display("FAIL %s sck edges: got %0d want %0d", name, edge_tot - e0, 2 * D); end
        n_cmp++;
        if (ss_bad_tot != s0) begin n_bad++; $display("FAIL %s ss_n during frame: got %0d bad cycles want 0 (want %b)", name, ss_bad_tot - s0, exp_ss); end
        n_cmp++;
        if (slv_rx !== tx) begin n_bad++; $display("FAIL %s slave saw: got %h want %h", name, slv_rx, tx); end
        n_cmp++;
        if (bus.sck !== cpol) begin n_bad++; $display("FAIL %s sck idle: got %b want %b", name, bus.sck, cpol); end
    endtask

    task automatic check_reset_outputs(input string name);
        n_cmp++; if (bus.sck !== 1'b0) begin n_bad++; $display("FAIL %s sck: got %b want 0", name, bus.sck); end
        n_cmp++; if (bus.mosi !== 1'b0) begin n_bad++; $display("FAIL %s mosi: got %b want 0", name, bus.mosi); end
        n_cmp++; if (bus.ss_n !== 4'b1111) begin n_bad++; $display("FAIL %s ss_n: got %b want 1111", name, bus.ss_n); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL %s busy: got %b want 0", name, bus.busy); end
        n_cmp++; if (bus.rx_data !== 8'h00) begin n_bad++; $display("FAIL %s rx_data: got %h want 00", name, bus.rx_data); end
        n_cmp++; if (bus.rx_valid !== 1'b0) begin n_bad++; $display("FAIL %s rx_valid: got %b want 0", name, bus.rx_valid); end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("reset");
        n_cmp++; if (bus3.ss_n !== 3'b111) begin n_bad++; $display("FAIL reset ss_n3: got %b want 111", bus3.ss_n); end
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk); #1;
    endtask

    task automatic test_basic();
        check_frame("basic_a5", 8'hA5, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00);
    endtask

    task automatic test_modes();
        for (int m = 0; m < 4; m++) begin
            logic [DW-1:0] div;
            div = DW'($urandom_range(0, 3));
            check_frame($sformatf("mode%0d", m), 8'h3C, 2'd2, m[1], m[0], div, 1'b0, 8'hC3);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            logic [D-1:0] tx, word;
            logic [1:0] sel, mode;
            tx   = D'($urandom);
            word = D'($urandom);
            sel  = 2'($urandom_range(0, 3));
            mode = 2'($urandom_range(0, 3));
            check_frame($sformatf("rand%0d", i), tx, sel, mode[1], mode[0],
                        DW'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), word);
        end
    endtask

    task automatic test_div_extremes();
        check_frame("div_min", 8'h96, 2'd1, 1'b1, 1'b1, 8'd0, 1'b1, 8'h00);
        check_frame("div_max", 8'h69, 2'd3, 1'b0, 1'b1, 8'hFF, 1'b0, 8'hE7);
    endtask

    task automatic test_start_ignored();
        int e0, r0;
        bit ok;
        loop_en = 1'b1;
        r0 = rxv_tot; e0 = edge_tot;
        start_frame(8'h12, 2'd1, 1'b0, 1'b0, 8'd1);
        wait_edges(e0, 5, 100, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL ignore edge5 timeout: got %0d edges want 5", edge_tot - e0); end
        bus.tx_data = 8'hFF;
        bus.start   = 1'b1;
        @(negedge clk); #1;
        bus.start   = 1'b0;
        wait_rx(100, ok);
        n_cmp++;
        if (bus.rx_data !== 8'h12) begin n_bad++; $display("FAIL ignore rx_data: got %h want 12", bus.rx_data); end
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (rxv_tot - r0 != 1) begin n_bad++; $display("FAIL ignore rx_valid count: got %0d want 1", rxv_tot - r0); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL ignore busy after: got %b want 0", bus.busy); end
    endtask

    task automatic test_bad_sel();
        int b0, r0;
        bit ok;
        logic [D-1:0] tx;
        b0 = busy3_tot; r0 = rxv3_tot;
        bus3.tx_data = 8'h33; bus3.ss_sel = 2'd3; bus3.c_pol = 1'b0; bus3.c_ph = 1'b0; bus3.clk_div = 8'd0;
        bus3.start = 1'b1;
        @(negedge clk); #1;
        bus3.start = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        n_cmp++; if (busy3_tot != b0) begin n_bad++; $display("FAIL badsel busy: got %0d cycles want 0", busy3_tot - b0); end
        n_cmp++; if (rxv3_tot != r0) begin n_bad++; $display("FAIL badsel rx_valid: got %0d want 0", rxv3_tot - r0); end
        tx = D'($urandom);
        bus3.tx_data = tx; bus3.ss_sel = 2'd2;
        bus3.start = 1'b1;
        @(negedge clk); #1;
        bus3.start = 1'b0;
        n_cmp++; if (bus3.ss_n !== 3'b011) begin n_bad++; $display("FAIL sel2 ss_n3: got %b want 011", bus3.ss_n); end
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus3.rx_valid) begin ok = 1'b1; break; end
            @(negedge clk); #1;
        end
        n_cmp++; if (!ok || bus3.rx_data !== tx) begin n_bad++; $display("FAIL sel2 rx3: got %h (valid %b) want %h", bus3.rx_data, ok, tx); end
    endtask

    task automatic test_reset_mid();
        int e0, r0;
        bit ok;
        loop_en = 1'b1;
        e0 = edge_tot;
        start_frame(D'($urandom), 2'd3, 1'b1, 1'($urandom_range(0, 1)), 8'd2);
        wait_edges(e0, 7, 200, ok);
        n_cmp++;
        if (!ok) begin n_bad++; $display("FAIL midreset edge7 timeout: got %0d edges want 7", edge_tot - e0); end
        r0 = rxv_tot;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (rxv_tot != r0) begin n_bad++; $display("FAIL midreset rx_valid: got %0d pulses want 0", rxv_tot - r0); end
        rst_n = 1'b1;
        @(negedge clk); #1;
        check_frame("after_reset", 8'h5A, 2'd0, 1'b0, 1'b0, 8'd1, 1'b1, 8'h00);
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [D-1:0] r1, r2;
        loop_en = 1'b1;
        rx_q.delete();
        bus.tx_data = 8'h81; bus.ss_sel = 2'd1; bus.c_pol = 1'b0; bus.c_ph = 1'b1; bus.clk_div = 8'd0;
        cfg_cpol = 1'b0; cfg_cpha = 1'b1; exp_ss = 4'b1101;
        bus.start = 1'b1;
        @(negedge clk); #1;
        bus.tx_data = 8'h7E;
        wait_rx(60, ok);
        n_cmp++;
        if (!ok || bus.ss_n !== 4'b1111 || bus.busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b gap: got ss_n %b busy %b valid %b want 1111 0 1", bus.ss_n, bus.busy, ok);
        end
        @(negedge clk); #1;
        bus.start = 1'b0;
        n_cmp++;
        if (bus.busy !== 1'b1 || bus.ss_n !== 4'b1101) begin
            n_bad++; $display("FAIL b2b restart: got busy %b ss_n %b want 1 1101", bus.busy, bus.ss_n);
        end
        wait_rx(60, ok);
        r1 = 8'h00; r2 = 8'h00;
        if (rx_q.size() > 0) r1 = rx_q.pop_front();
        if (rx_q.size() > 0) r2 = rx_q.pop_front();
        n_cmp++; if (r1 !== 8'h81) begin n_bad++; $display("FAIL b2b first rx: got %h want 81", r1); end
        n_cmp++; if (r2 !== 8'h7E) begin n_bad++; $display("FAIL b2b second rx: got %h want 7e", r2); end
        @(negedge clk); #1;
    endtask

    task automatic test_lsb_first();
        logic exp_first;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = 1'b1;
        exp_first = 1'b1;
`else
        exp_first = 1'b0;
`endif
        loop_en = 1'b1;
        start_frame(8'h01, 2'd0, 1'b0, 1'b0, 8'd1);
        begin
            bit ok;
            wait_rx(60, ok);
        end
        n_cmp++; if (slv_first !== exp_first) begin n_bad++; $display("FAIL lsb first mosi bit: got %b want %b", slv_first, exp_first); end
        n_cmp++; if (bus.rx_data !== 8'h01) begin n_bad++; $display("FAIL lsb loopback rx: got %h want 01", bus.rx_data); end
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
`endif
        @(negedge clk); #1;
    endtask

    initial begin
        bus.start = 1'b0; bus.ss_sel = '0; bus.c_pol = 1'b0; bus.c_ph = 1'b0; bus.clk_div = '0; bus.tx_data = '0;
        bus3.start = 1'b0; bus3.ss_sel = '0; bus3.c_pol = 1'b0; bus3.c_ph = 1'b0; bus3.clk_div = '0; bus3.tx_data = '0;
`ifdef SPI_LSB_FIRST_EN
        bus.lsb_first = 1'b0;
        bus3.lsb_first = 1'b0;
`endif
        test_reset();
        test_basic();
        test_modes();
        test_random();
        test_div_extremes();
        test_start_ignored();
        test_bad_sel();
        test_reset_mid();
        test_back_to_back();
        test_lsb_first();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
